uart_tx_engine: RTL and testbench

Parametrised UART transmit engine that merges control FSM, serializer, parity generator and output mux into one block. It accepts a parallel word on a valid strobe and drives a complete serial frame on TX_OUT. The frame is start bit, DATA_WIDTH data bits LSB first, optional even/odd parity, and one or two stop bits. It sits between the system-side data source and the TX pin. CLK is the bit-rate clock: one frame bit per CLK cycle.

---
 rtl/uart_tx_pkg.sv | 29 ++
 rtl/uart_tx_serializer.sv | 40 ++++
 rtl/uart_tx_engine.sv | 124 ++++++++++++
 tb/tb_uart_tx_engine.sv | 133 +++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit engine: gray-coded FSM states, output mux selects
// and parity type constants.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'b000,
      StStart  = 3'b001,
      StData   = 3'b011,
      StParity = 3'b010,
      StStop1  = 3'b110,
      StStop2  = 3'b111
   } tx_state_e;

   typedef enum logic [1:0] {
      SelOne  = 2'b00,
      SelZero = 2'b01,
      SelData = 2'b10,
      SelPar  = 2'b11
   } tx_sel_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Bit counter width; a one-bit word still needs a one-bit counter.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// LSB-first shift register with bit counter; o_bit is the bit that will sit on the line after
// the coming edge, o_done flags the last data bit.
module uart_tx_serializer
   import uart_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  i_load,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_en,
   output logic                  o_bit,
   output logic                  o_done
);

   localparam int unsigned CntW = cnt_width(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] w_shift_d;
   logic [CntW-1:0]       r_cnt;

   assign w_shift_d = i_en ? (r_shift >> 1) : r_shift;
   assign o_bit     = w_shift_d[0];
   assign o_done    = (r_cnt == CntW'(DATA_WIDTH - 1));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (i_load) begin
         r_shift <= i_data;
         r_cnt   <= '0;
      end else if (i_en) begin
         r_shift <= w_shift_d;
         r_cnt   <= o_done ? '0 : r_cnt + CntW'(1);
      end
   end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: frame FSM, parity and registered output mux around the serializer.
// All outputs are registered from next-state values so they move with the state.
module uart_tx_engine
   import uart_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
   output logic                  TX_OUT,
   output logic                  busy,
   output logic                  tx_done
);

   tx_state_e r_state;
   tx_state_e w_state_d;
   tx_sel_e   w_sel;

   logic r_par_en;
   logic r_par_typ;
   logic r_stop2;
   logic r_par;

   logic w_final_stop;
   logic w_accept;
   logic w_final_d;
   logic w_tx_d;
   logic w_par_d;
   logic w_ser_bit;
   logic w_ser_done;

   assign w_final_stop = (r_state == StStop2) || ((r_state == StStop1) && !r_stop2);
   assign w_accept     = Data_Valid && ((r_state == StIdle) || w_final_stop);
   assign w_par_d      = (PAR_TYP == PAR_ODD) ? ~(^P_DATA) : ^P_DATA;

   uart_tx_serializer #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_serializer (
      .CLK   (CLK),
      .RST   (RST),
      .i_load(w_accept),
      .i_data(P_DATA),
      .i_en  (r_state == StData),
      .o_bit (w_ser_bit),
      .o_done(w_ser_done)
   );

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:   w_state_d = w_accept ? StStart : StIdle;
         StStart:  w_state_d = StData;
         StData: begin
            if (w_ser_done) w_state_d = r_par_en ? StParity : StStop1;
         end
         StParity: w_state_d = StStop1;
         StStop1: begin
            if (r_stop2)       w_state_d = StStop2;
            else if (w_accept) w_state_d = StStart;
            else               w_state_d = StIdle;
         end
         StStop2:  w_state_d = w_accept ? StStart : StIdle;
         default:  w_state_d = StIdle;
      endcase
   end

   always_comb begin
      w_sel = SelOne;
      unique case (w_state_d)
         StStart:  w_sel = SelZero;
         StData:   w_sel = SelData;
         StParity: w_sel = SelPar;
         default:  w_sel = SelOne;
      endcase
   end

   always_comb begin
      w_tx_d = 1'b1;
      unique case (w_sel)
         SelOne:  w_tx_d = 1'b1;
         SelZero: w_tx_d = 1'b0;
         SelData: w_tx_d = w_ser_bit;
         SelPar:  w_tx_d = r_par;
         default: w_tx_d = 1'b1;
      endcase
   end

   // Entry into STOP1 never coincides with acceptance, so the shadow r_stop2 is current.
   assign w_final_d = (w_state_d == StStop2) || ((w_state_d == StStop1) && !r_stop2);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state   <= StIdle;
         TX_OUT    <= 1'b1;
         busy      <= 1'b0;
         tx_done   <= 1'b0;
         r_par_en  <= 1'b0;
         r_par_typ <= PAR_EVEN;
         r_stop2   <= 1'b0;
         r_par     <= 1'b0;
      end else begin
         r_state <= w_state_d;
         TX_OUT  <= w_tx_d;
         busy    <= (w_state_d != StIdle);
         tx_done <= w_final_d;
         if (w_accept) begin
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
            r_stop2   <= STOP2;
            r_par     <= w_par_d;
         end
      end
   end

   // Latched parity type is kept for visibility; the parity bit itself is latched pre-computed.
   logic w_unused;
   assign w_unused = r_par_typ;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: 8-bit and 5-bit instances, hand-computed frame vectors.
module tb_uart_tx_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] pdata;
   logic        pe, pt, s2;
   logic        dv8, dv5;
   logic        tx8, busy8, done8;
   logic        tx5, busy5, done5;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   uart_tx_engine #(.DATA_WIDTH(8)) u_dut8 (
      .CLK(clk), .RST(rst), .P_DATA(pdata[7:0]), .Data_Valid(dv8), .PAR_EN(pe),
      .PAR_TYP(pt), .STOP2(s2), .TX_OUT(tx8), .busy(busy8), .tx_done(done8)
   );

   uart_tx_engine #(.DATA_WIDTH(5)) u_dut5 (
      .CLK(clk), .RST(rst), .P_DATA(pdata[4:0]), .Data_Valid(dv5), .PAR_EN(pe),
      .PAR_TYP(pt), .STOP2(s2), .TX_OUT(tx5), .busy(busy5), .tx_done(done5)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic sample(input int inst, output logic tx, output logic b, output logic d);
      if (inst == 0) begin tx = tx8; b = busy8; d = done8; end
      else           begin tx = tx5; b = busy5; d = done5; end
   endtask

   task automatic set_dv(input int inst, input logic v);
      if (inst == 0) dv8 = v;
      else           dv5 = v;
   endtask

   task automatic check_idle(input int inst, input string tag);
      logic tx, b, d;
      sample(inst, tx, b, d);
      check({tag, ".tx"}, tx, 1'b1);
      check({tag, ".busy"}, b, 1'b0);
      check({tag, ".done"}, d, 1'b0);
   endtask

   // exp_tx/exp_done are written in time order: cycle 0 is bit len-1.
   // act_kind: 1 scramble inputs, 2 stray Data_Valid pulse, 3 queue 0x0F back-to-back.
   task automatic run(input int inst, input string tag, input logic [15:0] data, input logic p_en,
                      input logic p_typ, input logic st2, input logic [31:0] exp_tx,
                      input logic [31:0] exp_done, input int len, input int act_cyc,
                      input int act_kind);
      logic tx, b, d;
      @(negedge clk);
      pdata = data; pe = p_en; pt = p_typ; s2 = st2;
      set_dv(inst, 1'b1);
      @(posedge clk); #1;
      for (int i = 0; i < len; i++) begin
         set_dv(inst, 1'b0);
         sample(inst, tx, b, d);
         check($sformatf("%s.tx[%0d]", tag, i), tx, exp_tx[len-1-i]);
         check($sformatf("%s.busy[%0d]", tag, i), b, 1'b1);
         check($sformatf("%s.done[%0d]", tag, i), d, exp_done[len-1-i]);
         if (i == act_cyc) begin
            case (act_kind)
               1: begin pdata = 16'hFFFF; pe = 1'b0; pt = 1'b1; s2 = 1'b0; end
               2: set_dv(inst, 1'b1);
               3: begin pdata = 16'h000F; set_dv(inst, 1'b1); end
               default: ;
            endcase
         end
         @(posedge clk); #1;
      end
      set_dv(inst, 1'b0);
      check_idle(inst, {tag, ".end"});
      @(posedge clk); #1;
      check_idle(inst, {tag, ".end2"});
   endtask

   // Starts a plain frame, aborts it with reset while data bit 3 (a 0) is on the line.
   task automatic reset_mid(input int inst, input string tag, input logic [15:0] data);
      logic tx, b, d;
      @(negedge clk);
      pdata = data; pe = 1'b0; pt = 1'b0; s2 = 1'b0;
      set_dv(inst, 1'b1);
      @(posedge clk); #1;
      set_dv(inst, 1'b0);
      repeat (4) begin @(posedge clk); #1; end
      sample(inst, tx, b, d);
      check({tag, ".bit3"}, tx, 1'b0);
      check({tag, ".busy_pre"}, b, 1'b1);
      #2 rst = 1'b0;
      #1 check_idle(inst, {tag, ".async"});
      @(posedge clk); #1;
      check_idle(inst, {tag, ".held"});
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      check_idle(inst, {tag, ".released"});
   endtask

   initial begin
      rst = 1'b0; pdata = '0; pe = 1'b0; pt = 1'b0; s2 = 1'b0; dv8 = 1'b0; dv5 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_idle(0, "reset8");
      check_idle(1, "reset5");
      @(negedge clk) rst = 1'b1;

      run(0, "a5_plain", 16'h00A5, 1'b0, 1'b0, 1'b0, 32'b0101001011, 32'd1, 10, -1, 0);
      run(0, "a5_even", 16'h00A5, 1'b1, 1'b0, 1'b0, 32'b01010010101, 32'd1, 11, -1, 0);
      run(0, "a5_odd", 16'h00A5, 1'b1, 1'b1, 1'b0, 32'b01010010111, 32'd1, 11, -1, 0);
      run(0, "01_stop2", 16'h0001, 1'b1, 1'b0, 1'b1, 32'b010000000111, 32'd1, 12, 3, 1);
      run(0, "b2b", 16'h0055, 1'b0, 1'b0, 1'b0, 32'b01010101010111100001,
          32'b00000000010000000001, 20, 9, 3);
      run(0, "dv_ignored", 16'h00A5, 1'b0, 1'b0, 1'b0, 32'b0101001011, 32'd1, 10, 4, 2);
      reset_mid(0, "rst8", 16'h00A5);
      run(0, "3c", 16'h003C, 1'b0, 1'b0, 1'b0, 32'b0001111001, 32'd1, 10, -1, 0);

      run(1, "w5_13", 16'h0013, 1'b0, 1'b0, 1'b0, 32'b0110011, 32'd1, 7, -1, 0);
      reset_mid(1, "rst5", 16'h0013);
      run(1, "w5_13_post", 16'h0013, 1'b0, 1'b0, 1'b0, 32'b0110011, 32'd1, 7, -1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
